spi_xfer_sequencer: RTL
=======================

# spi_xfer_sequencer

Transaction front-end that sits directly upstream of the SPI master with single chip select. Accepts one multi-byte SPI transaction per request (up to MAX_BYTES_PER_CS bytes under one CS-low window) over a valid/ready interface. Feeds the master one byte at a time through its TX byte/data-valid/ready handshake, collects each MISO byte from the master's RX data-valid pulses, and returns the assembled response word over a valid/ready interface.

## Interface
- MAX_BYTES_PER_CS, 2: bytes per CS-low window; must match the SPI master instance.
- TIMEOUT_CLKS, 1024: wait-for-RX watchdog limit in i_Clk cycles (used only with SPI_SEQ_TIMEOUT_EN).
- CNT_W, $clog2(MAX_BYTES_PER_CS+1): width of count fields (derived, not overridden).

Ports:
- i_Clk  in  1  single clock for all logic.
- i_Rst  in  1  reset, synchronous and active-high.
- i_Req_Valid  in  1  request present.
- o_Req_Ready  out  1  request accepted when high with i_Req_Valid.
- i_Req_Len  in  CNT_W  byte count.
- i_Req_Data  in  8*MAX_BYTES_PER_CS  TX bytes; byte k = bits [8k+7:8k]; byte 0 sent first.
- o_Rsp_Valid  out  1  response present.
- i_Rsp_Ready  in  1  response consumed.
- o_Rsp_Data  out  8*MAX_BYTES_PER_CS  RX bytes, same packing; unused bytes 0.
- o_Rsp_Err  out  1  illegal length or timeout.
- o_TX_Count  out  CNT_W  to master i_TX_Count.
- o_TX_Byte  out  8  to master i_TX_Byte.
- o_TX_DV  out  1  to master i_TX_DV; one-cycle pulse.
- i_TX_Ready  in  1  from master o_TX_Ready.
- i_RX_DV  in  1  from master o_RX_DV.
- i_RX_Byte  in  8  from master o_RX_Byte.
- o_Busy  out  1  state != IDLE.

## Operation
- States: IDLE, SEND, WAIT_RX, RESP.
- IDLE: o_Req_Ready=1. On i_Req_Valid:
  - latch len/data, clear RX buffer, index=0.
  - If len in 1..MAX_BYTES_PER_CS, go SEND.
  - Otherwise (len 0 or >MAX), go RESP with o_Rsp_Err=1 and data 0. No SPI activity.
- SEND: wait for i_TX_Ready=1. Then register o_TX_DV=1 and o_TX_Byte=byte[index]; go WAIT_RX.
- WAIT_RX: on i_RX_DV, store i_RX_Byte at byte[index] and increment index.
  - If index+1==len, go RESP.
  - Otherwise go SEND.
  - i_RX_DV in any other state is ignored.
- RESP: o_Rsp_Valid held high with stable data/err until i_Rsp_Ready; then IDLE.
- o_TX_Count holds the latched len from accept until return to IDLE; 0 in IDLE.
- One transaction outstanding; o_Req_Ready=0 outside IDLE.
- Simultaneous i_RX_DV and i_TX_Ready in WAIT_RX: capture RX. i_TX_Ready is a level, so SEND sees it on the next cycle.
- Reset values: o_Req_Ready=1 (the cycle after reset), all other outputs 0, state IDLE, buffers 0.
- Reset mid-transaction aborts immediately with no response. The SPI master shares i_Rst so CS releases.

## Timing
- Accept in cycle 0. SEND in cycle 1. o_TX_DV high in cycle 2 if i_TX_Ready was high in cycle 1.
- o_TX_DV is registered: high exactly one cycle per byte, never twice for one index.
- Next byte's o_TX_DV no earlier than 2 cycles after the previous byte's i_RX_DV.
- o_Rsp_Valid rises the cycle after the last i_RX_DV.
- Illegal-length response: o_Rsp_Valid in cycle 1.
- o_Req_Ready rises the cycle after the i_Rsp_Ready handshake.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - counter runs in WAIT_RX, cleared on entry.
  - Reaching TIMEOUT_CLKS without i_RX_DV goes to RESP with o_Rsp_Err=1; bytes captured so far are kept, the rest are 0.
- SPI_SEQ_TIMEOUT_EN undefined: no counter, WAIT_RX waits indefinitely, o_Rsp_Err is set only for illegal length.

## Structure
- Package spi_seq_pkg holds:
  - state enum (IDLE, SEND, WAIT_RX, RESP).
  - localparam DEFAULT_TIMEOUT_CLKS.
- Sub-module spi_seq_watchdog (counter, clear, expire). Instantiated only under SPI_SEQ_TIMEOUT_EN.

## Test plan
- Len 2, data 16'hADBE, master (SPI_MODE 3, CLKS_PER_HALF_BIT 4) with MISO looped to MOSI:
  - MOSI carries 8'hBE then 8'hAD MSB-first under one CS-low.
  - o_Rsp_Data=16'hADBE, err 0, exactly 2 o_TX_DV pulses.
- Len 1, data 8'h03, MISO tied 1: o_Rsp_Data=16'h00FF, o_TX_Count=1 during transfer.
- Len 0, then len 3 (MAX=2): each gets o_Rsp_Valid in cycle 1 with err 1 and data 0; o_TX_DV never asserts.
- i_Rsp_Ready held low 20 cycles after a transfer: o_Rsp_Valid and data stable; o_Req_Ready=0; a new i_Req_Valid is not accepted until the handshake.
- i_Rst pulsed during WAIT_RX of byte 1: next cycle all outputs at reset values, no o_Rsp_Valid; a following len-2 request completes correctly.
- With SPI_SEQ_TIMEOUT_EN, TIMEOUT_CLKS=16, i_RX_DV suppressed: o_Rsp_Err=1 exactly 16 cycles after WAIT_RX entry.

Source files
------------

// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_seq_pkg
// Description : Shared state encoding and defaults for the SPI transaction
//               sequencer and its watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SEND    = 2'd1;
    localparam state_t ST_WAIT_RX = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

    localparam int DEFAULT_TIMEOUT_CLKS = 1024;

endpackage
`default_nettype wire

// File: rtl/spi_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : spi_seq_watchdog
// Description : Wait-for-RX watchdog; counts while i_Run is high and flags
//               o_Expire on the TIMEOUT_CLKS-th cycle since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_seq_watchdog #(
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clear,
    input  logic i_Run,
    output logic o_Expire
);

    localparam int c_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CLKS - 1);

    logic [c_W-1:0] r_Count;

    assign o_Expire = i_Run && (r_Count == c_LAST);

    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clear) begin
            r_Count <= '0;
        end else if (i_Run && !o_Expire) begin
            r_Count <= r_Count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_sequencer
// Description : Splits one multi-byte request into per-byte SPI master
//               handshakes and returns the assembled MISO word.
//               Optional RX watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int TIMEOUT_CLKS     = DEFAULT_TIMEOUT_CLKS,
    parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Req_Valid,
    output logic                          o_Req_Ready,
    input  logic [CNT_W-1:0]              i_Req_Len,
    input  logic [8*MAX_BYTES_PER_CS-1:0] i_Req_Data,
    output logic                          o_Rsp_Valid,
    input  logic                          i_Rsp_Ready,
    output logic [8*MAX_BYTES_PER_CS-1:0] o_Rsp_Data,
    output logic                          o_Rsp_Err,
    output logic [CNT_W-1:0]              o_TX_Count,
    output logic [7:0]                    o_TX_Byte,
    output logic                          o_TX_DV,
    input  logic                          i_TX_Ready,
    input  logic                          i_RX_DV,
    input  logic [7:0]                    i_RX_Byte,
    output logic                          o_Busy
);

    localparam int               c_DW  = 8 * MAX_BYTES_PER_CS;
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_BYTES_PER_CS);

    if (MAX_BYTES_PER_CS < 1 || TIMEOUT_CLKS < 1) begin : g_bad_params
        $error("spi_xfer_sequencer: MAX_BYTES_PER_CS and TIMEOUT_CLKS must be >= 1");
    end

    state_t            r_State;
    logic [CNT_W-1:0]  r_Len;
    logic [CNT_W-1:0]  r_Idx;
    logic [c_DW-1:0]   r_TxData;
    logic [c_DW-1:0]   r_RxData;
    logic              r_Err;
    logic              r_TX_DV;
    logic [7:0]        r_TX_Byte;
    logic              w_Len_Ok;
    logic              w_Last;
    logic              w_Expire;
    logic [CNT_W+2:0]  w_Bit_Sel;

    assign w_Len_Ok  = (i_Req_Len != '0) && (i_Req_Len <= c_MAX);
    assign w_Last    = ((r_Idx + 1'b1) == r_Len);
    assign w_Bit_Sel = {r_Idx, 3'b000};

`ifdef SPI_SEQ_TIMEOUT_EN
    logic w_Wdog_Clear;
    logic w_Wdog_Run;

    // Cleared on the SEND->WAIT_RX transition so the count starts at zero on entry.
    assign w_Wdog_Clear = (r_State == ST_SEND) && i_TX_Ready;
    assign w_Wdog_Run   = (r_State == ST_WAIT_RX);

    spi_seq_watchdog #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_watchdog (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Clear  (w_Wdog_Clear),
        .i_Run    (w_Wdog_Run),
        .o_Expire (w_Expire)
    );
`else
    assign w_Expire = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State   <= ST_IDLE;
            r_Len     <= '0;
            r_Idx     <= '0;
            r_TxData  <= '0;
            r_RxData  <= '0;
            r_Err     <= 1'b0;
            r_TX_DV   <= 1'b0;
            r_TX_Byte <= 8'h00;
        end else begin
            r_TX_DV <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (i_Req_Valid) begin
                        r_Len    <= i_Req_Len;
                        r_TxData <= i_Req_Data;
                        r_RxData <= '0;
                        r_Idx    <= '0;
                        r_Err    <= !w_Len_Ok;
                        r_State  <= w_Len_Ok ? ST_SEND : ST_RESP;
                    end
                end
                ST_SEND: begin
                    if (i_TX_Ready) begin
                        r_TX_DV   <= 1'b1;
                        r_TX_Byte <= r_TxData[w_Bit_Sel +: 8];
                        r_State   <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    // RX capture wins over a coincident watchdog expiry.
                    if (i_RX_DV) begin
                        r_RxData[w_Bit_Sel +: 8] <= i_RX_Byte;
                        r_Idx                    <= r_Idx + 1'b1;
                        r_State                  <= w_Last ? ST_RESP : ST_SEND;
                    end else if (w_Expire) begin
                        r_Err   <= 1'b1;
                        r_State <= ST_RESP;
                    end
                end
                default: begin
                    if (i_Rsp_Ready) begin
                        r_State <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_Req_Ready = (r_State == ST_IDLE);
    assign o_Rsp_Valid = (r_State == ST_RESP);
    assign o_Busy      = (r_State != ST_IDLE);
    assign o_Rsp_Data  = r_RxData;
    assign o_Rsp_Err   = r_Err;
    assign o_TX_Count  = (r_State == ST_IDLE) ? '0 : r_Len;
    assign o_TX_DV     = r_TX_DV;
    assign o_TX_Byte   = r_TX_Byte;

endmodule
`default_nettype wire
